// File: rtl/obj_det_pkg.sv
// Shared definitions for the suspicious-object alert sequencer.
//   STATE_W        width of the exported FSM state code
//   SUSP_RUN_W     width of the consecutive-suspicious-frame counter
//   EVT_W_DEFAULT  default width of the alarm event counter
//   state_e        FSM encoding; codes are visible to software through state_out
package obj_det_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned SUSP_RUN_W    = 8;
  localparam int unsigned EVT_W_DEFAULT = 16;

  localparam logic [STATE_W-1:0] ST_IDLE_CODE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_CAPTURE_CODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE_CODE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_MONITOR_CODE = 3'd3;
  localparam logic [STATE_W-1:0] ST_CONFIRM_CODE = 3'd4;
  localparam logic [STATE_W-1:0] ST_ALARM_CODE   = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    StIdle    = ST_IDLE_CODE,
    StCapture = ST_CAPTURE_CODE,
    StSettle  = ST_SETTLE_CODE,
    StMonitor = ST_MONITOR_CODE,
    StConfirm = ST_CONFIRM_CODE,
    StAlarm   = ST_ALARM_CODE
  } state_e;

endpackage

// File: rtl/frame_run_counter.sv
// Saturating consecutive-frame run counter.
//   clk, resetn  clock, asynchronous active-low reset
//   en           a frame completed this cycle and should be counted
//   hit          frame matched (increment); a non-matching frame restarts the run
//   clr          synchronous clear, overrides en
//   count        current run length, saturates at all-ones
//   tc           count has already reached TARGET
//   tc_next      this cycle's frame makes the run reach TARGET
module frame_run_counter #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TARGET = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             hit,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             tc_next
);

  localparam logic [CNT_W:0] TargetExt = (CNT_W+1)'(TARGET);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_inc;

  // One bit wider so the compare against TARGET never wraps.
  assign count_inc = (CNT_W+1)'(count_q) + (CNT_W+1)'(1);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (!hit) begin
        count_d = '0;
      end else if (count_q != '1) begin
        count_d = count_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign tc      = ((CNT_W+1)'(count_q) >= TargetExt);
  assign tc_next = en & hit & (count_inc >= TargetExt);

endmodule

// File: rtl/obj_det_alert_sequencer.sv
// Frame-level sequencer for the suspicious object detector: triggers reference capture once
// the camera is configured, lets the detector settle, debounces the per-frame suspicion flag,
// raises a latched alarm and re-captures the reference after software acknowledge.
//
// Build option: define OBJ_DET_ALERT_AUTOCLEAR_EN to let CLEAR_FRAMES consecutive clean frames
// clear the alarm as if it had been acknowledged. Without it CLEAR_FRAMES is unused.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   i2c_config_done     camera configured (level); dropping it returns to idle
//   frame_done          1-cycle pulse, detector flags valid
//   obj_detected        object flag, sampled on frame_done
//   susp_obj_detected   suspicion flag, sampled on frame_done
//   alarm_ack           software acknowledge pulse
//   rearm_req           request a fresh reference capture
//   start_capture       1-cycle pulse to detector control
//   alarm               latched alarm level
//   obj_present         object flag of the last observed (non-settle) frame
//   state_out           current FSM state code
//   susp_run            consecutive suspicious frames, saturating
//   alarm_count         alarms raised since reset, saturating
module obj_det_alert_sequencer
  import obj_det_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES = 4,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned CLEAR_FRAMES   = 8,
  parameter int unsigned EVT_W          = EVT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i2c_config_done,
  input  logic                  frame_done,
  input  logic                  obj_detected,
  input  logic                  susp_obj_detected,
  input  logic                  alarm_ack,
  input  logic                  rearm_req,
  output logic                  start_capture,
  output logic                  alarm,
  output logic                  obj_present,
  output logic [STATE_W-1:0]    state_out,
  output logic [SUSP_RUN_W-1:0] susp_run,
  output logic [EVT_W-1:0]      alarm_count
);

  state_e state_q, state_d;

  logic             start_capture_q;
  logic             alarm_q;
  logic             obj_present_q, obj_present_d;
  logic [EVT_W-1:0] alarm_count_q, alarm_count_d;

  logic in_watch;
  logic obs_state;

  assign in_watch  = (state_q == StMonitor) || (state_q == StConfirm);
  assign obs_state = in_watch || (state_q == StAlarm);

  // Settle: every frame counts; the counter idles at zero outside SETTLE.
  logic [SUSP_RUN_W-1:0] settle_cnt;
  logic                  settle_tc, settle_tc_next, settle_done;

  frame_run_counter #(
    .CNT_W  (SUSP_RUN_W),
    .TARGET (SETTLE_FRAMES)
  ) u_settle_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .en      (frame_done && (state_q == StSettle)),
    .hit     (1'b1),
    .clr     (state_q != StSettle),
    .count   (settle_cnt),
    .tc      (settle_tc),
    .tc_next (settle_tc_next)
  );

  // settle_tc covers SETTLE_FRAMES == 0, where no frame is waited for.
  assign settle_done = settle_tc | settle_tc_next;

  // Confirm: frames dropped by rearm or config loss must not advance the run.
  logic [SUSP_RUN_W-1:0] conf_cnt;
  logic                  conf_en, conf_clr, conf_tc, conf_tc_next;

  assign conf_en  = frame_done && in_watch && i2c_config_done && !rearm_req;
  assign conf_clr = (state_d == StCapture) || (state_d == StIdle);

  frame_run_counter #(
    .CNT_W  (SUSP_RUN_W),
    .TARGET (CONFIRM_FRAMES)
  ) u_confirm_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .en      (conf_en),
    .hit     (susp_obj_detected),
    .clr     (conf_clr),
    .count   (conf_cnt),
    .tc      (conf_tc),
    .tc_next (conf_tc_next)
  );

  logic clear_hit;

`ifdef OBJ_DET_ALERT_AUTOCLEAR_EN
  logic [SUSP_RUN_W-1:0] clear_cnt;
  logic                  clear_tc;

  // Clean-frame run while alarmed; a suspicious frame restarts it.
  frame_run_counter #(
    .CNT_W  (SUSP_RUN_W),
    .TARGET (CLEAR_FRAMES)
  ) u_clear_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .en      (frame_done && (state_q == StAlarm) && i2c_config_done && !alarm_ack),
    .hit     (!susp_obj_detected),
    .clr     (state_q != StAlarm),
    .count   (clear_cnt),
    .tc      (clear_tc),
    .tc_next (clear_hit)
  );

  logic unused_clear;
  assign unused_clear = ^{clear_cnt, clear_tc};
`else
  assign clear_hit = 1'b0;
`endif

  logic unused_cnt;
  assign unused_cnt = ^{settle_cnt, conf_tc};

  always_comb begin
    state_d = state_q;
    if ((state_q != StIdle) && !i2c_config_done) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i2c_config_done) state_d = StCapture;
        end
        // frame_done here is dropped on purpose: the reference is not valid yet.
        StCapture: state_d = StSettle;
        StSettle: begin
          if (rearm_req) begin
            state_d = StCapture;
          end else if (settle_done) begin
            state_d = StMonitor;
          end
        end
        StMonitor, StConfirm: begin
          if (rearm_req) begin
            state_d = StCapture;
          end else if (frame_done) begin
            if (susp_obj_detected) begin
              state_d = conf_tc_next ? StAlarm : StConfirm;
            end else begin
              state_d = StMonitor;
            end
          end
        end
        StAlarm: begin
          if (alarm_ack || clear_hit) state_d = StCapture;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    obj_present_d = obj_present_q;
    if (state_d == StCapture) begin
      obj_present_d = 1'b0;
    end else if (frame_done && obs_state && i2c_config_done) begin
      obj_present_d = obj_detected;
    end
  end

  always_comb begin
    alarm_count_d = alarm_count_q;
    if ((state_d == StAlarm) && (state_q != StAlarm) && (alarm_count_q != '1)) begin
      alarm_count_d = alarm_count_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      start_capture_q <= 1'b0;
      alarm_q         <= 1'b0;
      obj_present_q   <= 1'b0;
      alarm_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      start_capture_q <= (state_d == StCapture);
      alarm_q         <= (state_d == StAlarm);
      obj_present_q   <= obj_present_d;
      alarm_count_q   <= alarm_count_d;
    end
  end

  assign start_capture = start_capture_q;
  assign alarm         = alarm_q;
  assign obj_present   = obj_present_q;
  assign state_out     = state_q;
  assign susp_run      = conf_cnt;
  assign alarm_count   = alarm_count_q;

endmodule

// File: tb/tb_obj_det_alert_sequencer.sv
// Scoreboard bench for obj_det_alert_sequencer. Stimulus pushes the expected output snapshot for
// each event it provokes; the monitor pops and compares whenever the DUT shows an event
// (post-frame, probe request, start_capture pulse, alarm edge).
module tb_obj_det_alert_sequencer;

  localparam int KFrame = 0;
  localparam int KProbe = 1;
  localparam int KCap   = 2;
  localparam int KAlarm = 3;

  typedef struct {
    int          kind;
    logic [2:0]  st;
    logic [7:0]  run;
    logic        al;
    logic [15:0] cnt;
    logic        ob;
  } exp_t;

  exp_t sb[$];

  logic        clk = 1'b0;
  logic        resetn;
  logic        i2c_config_done;
  logic        frame_done;
  logic        obj_detected;
  logic        susp_obj_detected;
  logic        alarm_ack;
  logic        rearm_req;
  logic        start_capture;
  logic        alarm;
  logic        obj_present;
  logic [2:0]  state_out;
  logic [7:0]  susp_run;
  logic [15:0] alarm_count;

  logic probe;
  logic done;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  obj_det_alert_sequencer #(
    .CONFIRM_FRAMES (4),
    .SETTLE_FRAMES  (2),
    .CLEAR_FRAMES   (8),
    .EVT_W          (16)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .i2c_config_done   (i2c_config_done),
    .frame_done        (frame_done),
    .obj_detected      (obj_detected),
    .susp_obj_detected (susp_obj_detected),
    .alarm_ack         (alarm_ack),
    .rearm_req         (rearm_req),
    .start_capture     (start_capture),
    .alarm             (alarm),
    .obj_present       (obj_present),
    .state_out         (state_out),
    .susp_run          (susp_run),
    .alarm_count       (alarm_count)
  );

  function automatic void push(input int k, input int st, input int run, input int al,
                               input int cnt, input int ob);
    exp_t e;
    e.kind = k;
    e.st   = 3'(st);
    e.run  = 8'(run);
    e.al   = 1'(al);
    e.cnt  = 16'(cnt);
    e.ob   = 1'(ob);
    sb.push_back(e);
  endfunction

  task automatic expect_evt(input int kind, input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, got state=%0d run=%0d alarm=%0b count=%0d obj=%0b",
               name, state_out, susp_run, alarm, alarm_count, obj_present);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || state_out !== e.st || susp_run !== e.run || alarm !== e.al ||
          alarm_count !== e.cnt || obj_present !== e.ob) begin
        errors++;
        $display({"FAIL %s: got kind=%0d state=%0d run=%0d alarm=%0b count=%0d obj=%0b, ",
                  "required kind=%0d state=%0d run=%0d alarm=%0b count=%0d obj=%0b"},
                 name, kind, state_out, susp_run, alarm, alarm_count, obj_present,
                 e.kind, e.st, e.run, e.al, e.cnt, e.ob);
      end
    end
  endtask

  // Monitor: sole owner of checks/errors; also prints the summary.
  initial begin
    logic frame_prev;
    logic alarm_prev;
    checks     = 0;
    errors     = 0;
    frame_prev = 1'b0;
    alarm_prev = 1'b0;
    #2;
    forever begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expected events never seen, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (frame_prev) expect_evt(KFrame, "post_frame");
      if (probe) expect_evt(KProbe, "probe");
      if (start_capture) expect_evt(KCap, "start_capture");
      if (alarm !== alarm_prev) expect_evt(KAlarm, "alarm_edge");
      frame_prev = frame_done;
      alarm_prev = alarm;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic s, input logic o);
    frame_done        = 1'b1;
    susp_obj_detected = s;
    obj_detected      = o;
    tick(1);
    frame_done        = 1'b0;
    susp_obj_detected = 1'b0;
    obj_detected      = 1'b0;
    tick(1);
  endtask

  task automatic pulse_probe();
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  // Acknowledge from ALARM, then confirm SETTLE and walk it back to MONITOR.
  task automatic ack_and_resettle(input int cnt);
    push(KCap, 1, 0, 0, cnt, 0);
    push(KAlarm, 1, 0, 0, cnt, 0);
    alarm_ack = 1'b1;
    tick(1);
    alarm_ack = 1'b0;
    tick(1);
    push(KProbe, 2, 0, 0, cnt, 0);
    pulse_probe();
    push(KFrame, 2, 0, 0, cnt, 0); frame(1'b0, 1'b0);
    push(KFrame, 3, 0, 0, cnt, 0); frame(1'b0, 1'b0);
  endtask

  initial begin
    resetn            = 1'b0;
    i2c_config_done   = 1'b0;
    frame_done        = 1'b0;
    obj_detected      = 1'b0;
    susp_obj_detected = 1'b0;
    alarm_ack         = 1'b0;
    rearm_req         = 1'b0;
    probe             = 1'b0;
    done              = 1'b0;
    tick(3);
    resetn = 1'b1;
    push(KProbe, 0, 0, 0, 0, 0);
    pulse_probe();
    tick(2);

    // Config done -> one start_capture pulse, SETTLE, MONITOR after two frames.
    push(KCap, 1, 0, 0, 0, 0);
    i2c_config_done = 1'b1;
    tick(2);
    push(KProbe, 2, 0, 0, 0, 0);
    pulse_probe();
    push(KFrame, 2, 0, 0, 0, 0); frame(1'b0, 1'b0);
    push(KFrame, 3, 0, 0, 0, 0); frame(1'b0, 1'b0);

    // Four suspicious frames raise the alarm.
    push(KFrame, 4, 1, 0, 0, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 2, 0, 0, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 3, 0, 0, 0); frame(1'b1, 1'b0);
    push(KFrame, 5, 4, 1, 1, 1);
    push(KAlarm, 5, 4, 1, 1, 1);
    frame(1'b1, 1'b1);

    // Ack together with a suspicious frame: ack wins, recapture.
    push(KFrame, 1, 0, 0, 1, 0);
    push(KCap, 1, 0, 0, 1, 0);
    push(KAlarm, 1, 0, 0, 1, 0);
    alarm_ack         = 1'b1;
    frame_done        = 1'b1;
    susp_obj_detected = 1'b1;
    obj_detected      = 1'b1;
    tick(1);
    alarm_ack         = 1'b0;
    frame_done        = 1'b0;
    susp_obj_detected = 1'b0;
    obj_detected      = 1'b0;
    tick(1);
    push(KProbe, 2, 0, 0, 1, 0);
    pulse_probe();
    push(KFrame, 2, 0, 0, 1, 0); frame(1'b0, 1'b0);
    push(KFrame, 3, 0, 0, 1, 0); frame(1'b0, 1'b0);

    // 3 suspicious, 1 clean, 4 suspicious: alarm only on the last.
    push(KFrame, 4, 1, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 2, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 3, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 3, 0, 0, 1, 0); frame(1'b0, 1'b0);
    push(KFrame, 4, 1, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 2, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 3, 0, 1, 1); frame(1'b1, 1'b1);
    push(KFrame, 5, 4, 1, 2, 1);
    push(KAlarm, 5, 4, 1, 2, 1);
    frame(1'b1, 1'b1);
    ack_and_resettle(2);

    // Rearm during CONFIRM with two suspicious frames counted.
    push(KFrame, 4, 1, 0, 2, 1); frame(1'b1, 1'b1);
    push(KFrame, 4, 2, 0, 2, 1); frame(1'b1, 1'b1);
    push(KCap, 1, 0, 0, 2, 0);
    rearm_req = 1'b1;
    tick(1);
    rearm_req = 1'b0;
    tick(1);
    push(KProbe, 2, 0, 0, 2, 0);
    pulse_probe();
    push(KFrame, 2, 0, 0, 2, 0); frame(1'b0, 1'b0);
    push(KFrame, 3, 0, 0, 2, 0); frame(1'b0, 1'b0);

    // Alarm, then config loss: IDLE, alarm cleared, count kept; rearm ignored in IDLE.
    push(KFrame, 4, 1, 0, 2, 0); frame(1'b1, 1'b0);
    push(KFrame, 4, 2, 0, 2, 0); frame(1'b1, 1'b0);
    push(KFrame, 4, 3, 0, 2, 0); frame(1'b1, 1'b0);
    push(KFrame, 5, 4, 1, 3, 0);
    push(KAlarm, 5, 4, 1, 3, 0);
    frame(1'b1, 1'b0);
    push(KAlarm, 0, 0, 0, 3, 0);
    i2c_config_done = 1'b0;
    tick(2);
    rearm_req = 1'b1;
    tick(1);
    rearm_req = 1'b0;
    tick(1);
    push(KProbe, 0, 0, 0, 3, 0);
    pulse_probe();

    // Re-enable; a frame during CAPTURE is dropped so two more settle frames are needed.
    push(KCap, 1, 0, 0, 3, 0);
    push(KFrame, 2, 0, 0, 3, 0);
    i2c_config_done = 1'b1;
    tick(1);
    frame_done        = 1'b1;
    susp_obj_detected = 1'b1;
    obj_detected      = 1'b1;
    tick(1);
    frame_done        = 1'b0;
    susp_obj_detected = 1'b0;
    obj_detected      = 1'b0;
    tick(1);
    push(KFrame, 2, 0, 0, 3, 0); frame(1'b0, 1'b0);
    push(KFrame, 3, 0, 0, 3, 0); frame(1'b0, 1'b0);

    // Fourth alarm, then clean frames while alarmed.
    push(KFrame, 4, 1, 0, 3, 0); frame(1'b1, 1'b0);
    push(KFrame, 4, 2, 0, 3, 0); frame(1'b1, 1'b0);
    push(KFrame, 4, 3, 0, 3, 0); frame(1'b1, 1'b0);
    push(KFrame, 5, 4, 1, 4, 0);
    push(KAlarm, 5, 4, 1, 4, 0);
    frame(1'b1, 1'b0);
`ifdef OBJ_DET_ALERT_AUTOCLEAR_EN
    for (int i = 0; i < 7; i++) begin
      push(KFrame, 5, 4, 1, 4, 0); frame(1'b0, 1'b0);
    end
    push(KFrame, 5, 4, 1, 4, 0); frame(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      push(KFrame, 5, 4, 1, 4, 0); frame(1'b0, 1'b0);
    end
    push(KFrame, 1, 0, 0, 4, 0);
    push(KCap, 1, 0, 0, 4, 0);
    push(KAlarm, 1, 0, 0, 4, 0);
    frame(1'b0, 1'b0);
    push(KProbe, 2, 0, 0, 4, 0);
    pulse_probe();
`else
    for (int i = 0; i < 8; i++) begin
      push(KFrame, 5, 4, 1, 4, 0); frame(1'b0, 1'b0);
    end
    ack_and_resettle(4);
`endif

    // Reset mid-operation clears everything; with config still up it recaptures.
    push(KProbe, 0, 0, 0, 0, 0);
    push(KCap, 1, 0, 0, 0, 0);
    resetn = 1'b0;
    probe  = 1'b1;
    tick(1);
    probe  = 1'b0;
    resetn = 1'b1;
    tick(4);
    done = 1'b1;
  end

endmodule
